// File: rtl/song_seq_pkg.sv
// rtl/song_seq_pkg.sv - shared types, key codes and duration table for the song sequencer
//
// Purpose: sequencer state encoding, PS/2 key-code constants, note-byte
// duration-code table and the end-of-song marker used by song_seq_player
// and song_note_decode.
// Ports: none (package).

package song_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_NEXT
    } state_t;

    // Duration counts reach 256 units, so nine bits are needed.
    localparam int DUR_W = 9;

    localparam logic [7:0] END_MARKER = 8'h00;

    localparam logic [7:0] KEY_REL = 8'hF0;
    localparam logic [7:0] KEY_P1  = 8'h2B;
    localparam logic [7:0] KEY_P2  = 8'h34;
    localparam logic [7:0] KEY_P3  = 8'h33;
    localparam logic [7:0] KEY_P4  = 8'h3B;
    localparam logic [7:0] KEY_P5  = 8'h42;
    localparam logic [7:0] KEY_P6  = 8'h4B;
    localparam logic [7:0] KEY_P7  = 8'h4C;
    localparam logic [7:0] KEY_P10 = 8'h52;

    // Duration code (note byte [7:4]) to length in units; unknown codes give
    // zero, which the player treats as a note to skip.
    function automatic logic [DUR_W-1:0] dur_units(input logic [3:0] code);
        logic [DUR_W-1:0] u;
        case (code)
            4'hF:    u = 9'd16;
            4'h8:    u = 9'd32;
            4'h9:    u = 9'd48;
            4'h1:    u = 9'd64;
            4'h3:    u = 9'd96;
            4'h2:    u = 9'd128;
            4'h4:    u = 9'd256;
            default: u = 9'd0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/song_note_decode.sv
// rtl/song_note_decode.sv - combinational note byte to key code and duration decoder
//
// Purpose: split a note byte into the PS/2 key code for its pitch and its
// length in duration units. Rests and unknown pitches map to the release code.
// Ports:
//   note  in  8      note byte, [3:0] pitch, [7:4] duration code
//   key   out 8      pitch key code (8'hF0 for rest/unknown)
//   units out DUR_W  note length in units (0 = skip)

module song_note_decode
    import song_seq_pkg::*;
(
    input  logic [7:0]       note,
    output logic [7:0]       key,
    output logic [DUR_W-1:0] units
);

    always_comb begin
        key = KEY_REL;
        case (note[3:0])
            4'd1:    key = KEY_P1;
            4'd2:    key = KEY_P2;
            4'd3:    key = KEY_P3;
            4'd4:    key = KEY_P4;
            4'd5:    key = KEY_P5;
            4'd6:    key = KEY_P6;
            4'd7:    key = KEY_P7;
            4'd10:   key = KEY_P10;
            default: key = KEY_REL;
        endcase
        units = dur_units(note[7:4]);
    end

endmodule

// File: rtl/song_seq_player.sv
// rtl/song_seq_player.sv - multi-song note sequencer driving PS/2 key codes
//
// Purpose: replays songs from an external note ROM with tempo prescaling,
// pause/stop control and, when SONG_SEQ_LOOP_EN is defined, looping.
// Ports:
//   clock     in  1            system clock
//   k_tr      in  1            asynchronous active-low reset
//   start     in  1            begin play when idle
//   stop      in  1            abort play (highest priority)
//   pause     in  1            freeze the current note while high
//   loop      in  1            wrap at end of song (SONG_SEQ_LOOP_EN only)
//   song_sel  in  SEL_W        song index, latched on accepted start
//   rom_addr  out SEL_W+STEP_W {song, step}
//   rom_data  in  8            note byte, valid one cycle after rom_addr
//   key_code  out 8            key code, 8'hF0 = silence
//   playing   out 1            high while a song is in progress
//   done      out 1            one-cycle pulse on natural end
//   step      out STEP_W       current step index

module song_seq_player
    import song_seq_pkg::*;
#(
    parameter int NUM_SONGS = 4,
    parameter int MAX_STEPS = 128,
    parameter int TICK_DIV  = 50000,
    parameter int SEL_W     = $clog2(NUM_SONGS),
    parameter int STEP_W    = $clog2(MAX_STEPS)
) (
    input  logic                    clock,
    input  logic                    k_tr,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    pause,
    input  logic                    loop,
    input  logic [SEL_W-1:0]        song_sel,
    output logic [SEL_W+STEP_W-1:0] rom_addr,
    input  logic [7:0]              rom_data,
    output logic [7:0]              key_code,
    output logic                    playing,
    output logic                    done,
    output logic [STEP_W-1:0]       step
);

    localparam int                PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  song_q, song_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        pitch_q, pitch_d;
    logic [7:0]        key_q, key_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [DUR_W-1:0]  units_q, units_d, units_inc;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              playing_q, playing_d;
    logic              done_q, done_d;
    logic [7:0]        dec_key;
    logic [DUR_W-1:0]  dec_units;
    logic              end_hit;
    logic              wrap_song;

    song_note_decode u_decode (
        .note  (rom_data),
        .key   (dec_key),
        .units (dec_units)
    );

`ifdef SONG_SEQ_LOOP_EN
    assign wrap_song = loop;
`else
    logic loop_unused;
    assign loop_unused = loop;
    assign wrap_song   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        song_d    = song_q;
        step_d    = step_q;
        pitch_d   = pitch_q;
        dur_d     = dur_q;
        units_d   = units_q;
        pre_d     = pre_q;
        playing_d = playing_q;
        done_d    = 1'b0;
        key_d     = KEY_REL;
        end_hit   = 1'b0;
        units_inc = units_q + 1'b1;

        if (stop) begin
            state_d   = S_IDLE;
            playing_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    playing_d = 1'b0;
                    if (start) begin
                        song_d    = song_sel;
                        step_d    = '0;
                        playing_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    if (rom_data == END_MARKER) begin
                        end_hit = 1'b1;
                    end else begin
                        pitch_d = dec_key;
                        dur_d   = dec_units;
                        units_d = '0;
                        pre_d   = '0;
                        if (dec_units == '0) begin
                            state_d = S_NEXT;
                        end else begin
                            state_d = S_PLAY;
                            // Last unit of every note is released silence.
                            if (dec_units > 9'd1) key_d = dec_key;
                        end
                    end
                end
                S_PLAY: begin
                    // Paused: counters hold and key_code stays at the default release code.
                    if (!pause) begin
                        if (pre_q == PRE_LAST) begin
                            pre_d   = '0;
                            units_d = units_inc;
                            if (units_inc == dur_q) state_d = S_NEXT;
                            else if (units_inc < dur_q - 1'b1) key_d = pitch_q;
                        end else begin
                            pre_d = pre_q + 1'b1;
                            if (units_q < dur_q - 1'b1) key_d = pitch_q;
                        end
                    end
                end
                S_NEXT: begin
                    if (step_q == STEP_LAST) begin
                        end_hit = 1'b1;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (end_hit) begin
                if (wrap_song) begin
                    step_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    done_d    = 1'b1;
                    playing_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge k_tr) begin
        if (!k_tr) begin
            state_q   <= S_IDLE;
            song_q    <= '0;
            step_q    <= '0;
            pitch_q   <= KEY_REL;
            dur_q     <= '0;
            units_q   <= '0;
            pre_q     <= '0;
            key_q     <= KEY_REL;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            song_q    <= song_d;
            step_q    <= step_d;
            pitch_q   <= pitch_d;
            dur_q     <= dur_d;
            units_q   <= units_d;
            pre_q     <= pre_d;
            key_q     <= key_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign rom_addr = {song_q, step_q};
    assign key_code = key_q;
    assign playing  = playing_q;
    assign done     = done_q;
    assign step     = step_q;

endmodule

// File: tb/tb_song_seq_player.sv
// tb/tb_song_seq_player.sv - self-checking bench for song_seq_player

module tb_song_seq_player;

    localparam int NS = 2;
    localparam int MS = 8;
    localparam int TD = 4;
    localparam int SW = 1;
    localparam int PW = 3;
    localparam int AW = SW + PW;

    localparam int PH_IDLE = 0;
    localparam int PH_ADDR = 1;
    localparam int PH_DATA = 2;
    localparam int PH_NOTE = 3;
    localparam int PH_ADV  = 4;

    logic          clock = 1'b0;
    logic          k_tr  = 1'b0;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          pause = 1'b0;
    logic          loop  = 1'b0;
    logic [SW-1:0] song_sel = '0;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = 8'h00;
    logic [7:0]    key_code;
    logic          playing;
    logic          done;
    logic [PW-1:0] step;

    logic [7:0] rom [16];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state: where we are in the song, how far into the
    // current note (in clock cycles) and what the outputs must be next cycle.
    int            m_ph    = PH_IDLE;
    int            m_t     = 0;
    int            m_len   = 0;
    logic [7:0]    m_pitch = 8'hF0;
    logic [7:0]    m_key   = 8'hF0;
    logic          m_busy  = 1'b0;
    logic          m_done  = 1'b0;
    logic [SW-1:0] m_song  = '0;
    logic [PW-1:0] m_step  = '0;

    song_seq_player #(
        .NUM_SONGS (NS),
        .MAX_STEPS (MS),
        .TICK_DIV  (TD)
    ) dut (
        .clock    (clock),
        .k_tr     (k_tr),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .loop     (loop),
        .song_sel (song_sel),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .key_code (key_code),
        .playing  (playing),
        .done     (done),
        .step     (step)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    function automatic logic [7:0] pitch_of(input logic [3:0] p);
        case (p)
            4'd1:    return 8'h2B;
            4'd2:    return 8'h34;
            4'd3:    return 8'h33;
            4'd4:    return 8'h3B;
            4'd5:    return 8'h42;
            4'd6:    return 8'h4B;
            4'd7:    return 8'h4C;
            4'd10:   return 8'h52;
            default: return 8'hF0;
        endcase
    endfunction

    function automatic int units_of(input logic [3:0] d);
        case (d)
            4'hF:    return 16;
            4'h8:    return 32;
            4'h9:    return 48;
            4'h1:    return 64;
            4'h3:    return 96;
            4'h2:    return 128;
            4'h4:    return 256;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_t = 0; m_len = 0; m_pitch = 8'hF0;
        m_key = 8'hF0; m_busy = 1'b0; m_done = 1'b0; m_song = '0; m_step = '0;
    endtask

    task automatic model_end_song();
`ifdef SONG_SEQ_LOOP_EN
        if (loop) begin
            m_step = '0;
            m_ph   = PH_ADDR;
            return;
        end
`endif
        m_done = 1'b1;
        m_busy = 1'b0;
        m_ph   = PH_IDLE;
    endtask

    task automatic model_step();
        logic [7:0] b;
        m_done = 1'b0;
        m_key  = 8'hF0;
        if (stop) begin
            m_busy = 1'b0;
            m_ph   = PH_IDLE;
            return;
        end
        case (m_ph)
            PH_IDLE: if (start) begin
                m_song = song_sel; m_step = '0; m_busy = 1'b1; m_ph = PH_ADDR;
            end
            PH_ADDR: m_ph = PH_DATA;
            PH_DATA: begin
                b = rom[{m_song, m_step}];
                if (b == 8'h00) begin
                    model_end_song();
                end else begin
                    m_len   = units_of(b[7:4]) * TD;
                    m_pitch = pitch_of(b[3:0]);
                    m_t     = 0;
                    if (m_len == 0) begin
                        m_ph = PH_ADV;
                    end else begin
                        m_ph = PH_NOTE;
                        if (m_t < m_len - TD) m_key = m_pitch;
                    end
                end
            end
            PH_NOTE: if (!pause) begin
                m_t++;
                if (m_t == m_len) m_ph = PH_ADV;
                else if (m_t < m_len - TD) m_key = m_pitch;
            end
            PH_ADV: begin
                if (int'(m_step) == MS - 1) begin
                    model_end_song();
                end else begin
                    m_step = m_step + 1'b1;
                    m_ph   = PH_ADDR;
                end
            end
            default: m_ph = PH_IDLE;
        endcase
    endtask

    initial forever begin
        @(posedge clock or negedge k_tr);
        if (!k_tr) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clock);
        check("key_code", key_code, m_key);
        check("playing", playing, m_busy);
        check("done", done, m_done);
        check("step", step, m_step);
        check("rom_addr", rom_addr, {m_song, m_step});
    end

    task automatic play_start(input logic [SW-1:0] sel);
        song_sel = sel;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts cycles from the one after start is sampled until done is seen
    // (or maxc), optionally holding pause for p_len cycles from cycle p_at.
    task automatic wait_done(input int maxc, input int p_at, input int p_len,
                             output int c, output int nt, output int ma);
        c = 1; nt = 0; ma = int'(rom_addr);
        while (!done && c < maxc) begin
            if (p_len > 0 && c == p_at) pause = 1'b1;
            if (p_len > 0 && c == p_at + p_len) pause = 1'b0;
            if (key_code != 8'hF0) nt++;
            if (int'(rom_addr) > ma) ma = int'(rom_addr);
            @(negedge clock);
            c++;
        end
        pause = 1'b0;
    endtask

    initial begin
        int c, nt, ma, sum, tone;
        logic [3:0] pl [9];
        logic [3:0] dl [4];
        logic [7:0] b;
        pl = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd15};
        dl = '{4'hF, 4'h8, 4'h0, 4'h9};

        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'hF1; rom[1] = 8'h00;
        rom[8] = 8'hF5; rom[9] = 8'hFF; rom[10] = 8'h00;

        repeat (3) @(negedge clock);
        check("rst_key_code", key_code, 8'hF0);
        check("rst_playing", playing, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_step", step, 0);
        k_tr = 1'b1;
        @(negedge clock);

        // One 16-unit note of pitch 1: 60 cycles of 2B then release, done at 70.
        play_start(1'b0);
        check("t1_key_first", key_code, 8'hF0);
        wait_done(400, 0, 0, c, nt, ma);
        check("t1_cycles", c, 70);
        check("t1_tone", nt, 60);
        check("t1_playing", playing, 1'b0);
        repeat (3) @(negedge clock);

        // Song 1: pitch 5 note then a full rest, addresses 8..10.
        play_start(1'b1);
        wait_done(400, 0, 0, c, nt, ma);
        check("t2_cycles", c, 137);
        check("t2_tone", nt, 60);
        check("t2_max_addr", ma, 10);
        repeat (3) @(negedge clock);

        // Pause for 20 cycles mid-note stretches the song by exactly 20.
        play_start(1'b0);
        wait_done(400, 10, 20, c, nt, ma);
        check("t3_cycles", c, 90);
        check("t3_tone", nt, 60);
        repeat (3) @(negedge clock);

        // Stop mid-note, then restart from step 0.
        play_start(1'b0);
        repeat (20) @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check("t4_stop_key", key_code, 8'hF0);
        check("t4_stop_playing", playing, 1'b0);
        check("t4_stop_done", done, 1'b0);
        repeat (5) @(negedge clock);
        play_start(1'b0);
        wait_done(400, 0, 0, c, nt, ma);
        check("t4_restart_cycles", c, 70);

        // Eight notes with no marker, including a zero-duration note.
        sum = 0; tone = 0;
        for (int i = 0; i < 8; i++) begin
            b = {dl[$urandom_range(0, 3)], pl[$urandom_range(0, 8)]};
            if (i == 3) b = 8'h05;
            if (b == 8'h00) b = 8'hF1;
            rom[8 + i] = b;
            sum += units_of(b[7:4]) * TD;
            if (pitch_of(b[3:0]) != 8'hF0 && units_of(b[7:4]) > 0)
                tone += (units_of(b[7:4]) - 1) * TD;
        end
        play_start(1'b1);
        wait_done(3000, 0, 0, c, nt, ma);
        check("t5_cycles", c, sum + 25);
        check("t5_tone", nt, tone);
        check("t5_max_addr", ma, 15);
        repeat (3) @(negedge clock);

        loop = 1'b1;
        play_start(1'b1);
`ifdef SONG_SEQ_LOOP_EN
        wait_done(sum + 25 + 100, 0, 0, c, nt, ma);
        check("t5_loop_no_done", c, sum + 25 + 100);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
`else
        wait_done(3000, 0, 0, c, nt, ma);
        check("t5_loop_ignored", c, sum + 25);
`endif
        loop = 1'b0;
        repeat (3) @(negedge clock);

        // Asynchronous reset in the middle of a note.
        play_start(1'b0);
        repeat (10) @(negedge clock);
        #2 k_tr = 1'b0;
        #1;
        check("t6_rst_key", key_code, 8'hF0);
        check("t6_rst_playing", playing, 1'b0);
        check("t6_rst_addr", rom_addr, 0);
        check("t6_rst_step", step, 0);
        @(negedge clock);
        k_tr = 1'b1;
        @(negedge clock);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 7) == 0) rom[i] = 8'h00;
            else rom[i] = {dl[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
        end
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 149) == 0);
            song_sel = SW'($urandom_range(0, NS - 1));
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            if ($urandom_range(0, 49) == 0) loop = ~loop;
            @(negedge clock);
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/song_seq_player.md
# song_seq_player

Parametrised note sequencer that replays songs held in an external note ROM and drives PS/2-style key codes into the audio tone generator. It supersedes the fixed per-song player modules with one engine that supports multiple songs, run-time song select, a tempo prescaler, pause/stop control and optional looping. It sits between the game control FSM and the audio key-code decoder.

## Interface
- NUM_SONGS, 4: songs in ROM; power of two, ≥2.
- MAX_STEPS, 128: step slots per song; power of two.
- TICK_DIV, 50000: clock cycles per duration unit; ≥1.
- SEL_W, $clog2(NUM_SONGS): derived.
- STEP_W, $clog2(MAX_STEPS): derived.

- clock  in  1  system clock, all logic rising-edge.
- k_tr  in  1  asynchronous active-low reset.
- start  in  1  level-sampled; begins play when idle.
- stop  in  1  abort play; priority over start and pause.
- pause  in  1  hold position while high.
- loop  in  1  wrap to step 0 at end of song (SONG_SEQ_LOOP_EN only).
- song_sel  in  SEL_W  song index, latched on accepted start.
- rom_addr  out  SEL_W+STEP_W  {song_latched, step}, registered.
- rom_data  in  8  note byte; valid exactly 1 cycle after rom_addr changes.
- key_code  out  8  registered key code; 8'hF0 = release/silence.
- playing  out  1  high from accepted start until IDLE.
- done  out  1  one-cycle pulse on natural end (not on stop).
- step  out  STEP_W  current step index.

## Operation
- Note byte: [3:0] pitch, [7:4] duration code. 8'h00 = end-of-song marker.
- Pitch map: 1→2B, 2→34, 3→33, 4→3B, 5→42, 6→4B, 7→4C, 10→52, 15 (rest) and all others→F0.
- Duration map (units): F→16, 8→32, 9→48, 1→64, 3→96, 2→128, 4→256, others→0.
- States: IDLE, FETCH, LOAD, PLAY, NEXT.
- IDLE: key_code F0, playing 0. start&!stop → latch song_sel, step=0, FETCH.
- FETCH: rom_addr={song,step}; → LOAD next cycle.
- LOAD: latch rom_data. If 8'h00 → end handling. Else clear unit counter, → PLAY; duration 0 → NEXT directly (key_code stays F0).
- PLAY: prescaler counts TICK_DIV clocks per unit. key_code = pitch code while units < dur−1, F0 from unit dur−1 until dur. units == dur → NEXT.
- NEXT: step+1 → FETCH. step == MAX_STEPS−1 → end handling (implicit end).
- End handling: loop active → step=0, FETCH; else done pulse, → IDLE.
- pause in PLAY: prescaler and unit counter frozen, key_code forced F0; on release resumes exactly where frozen. pause ignored in other states (fetch proceeds, PLAY then freezes).
- stop in any state: → IDLE next cycle, key_code F0, no done.
- start while playing: ignored; song_sel changes ignored until next start.

## Timing
- Reset values: key_code 8'hF0, playing 0, done 0, rom_addr 0, step 0, state IDLE.
- start sampled cycle N → rom_addr valid N+1, data latched N+2, first pitch code on key_code N+3.
- Note of d units occupies d×TICK_DIV cycles in PLAY plus 3 cycles overhead (NEXT, FETCH, LOAD) during which key_code = F0.
- Prescaler and unit counter widths sized for 256 units × TICK_DIV; no wrap during a note.
- Reset mid-play: all state cleared asynchronously; key_code F0 immediately.
- stop and end marker same cycle: stop wins, no done.

## Configuration
- SONG_SEQ_LOOP_EN defined: loop input honoured as above; loop sampled at end handling.
- Undefined: loop input ignored; every end produces done and IDLE; no loop logic synthesised.

## Structure
- Package song_seq_pkg: state enum, pitch code constants (KEY_REL=8'hF0, etc.), duration-code table, END_MARKER=8'h00.
- Sub-module song_note_decode: combinational note byte → pitch key code and duration units; reused by later players.

## Test plan (TICK_DIV=4, MAX_STEPS=8, NUM_SONGS=2)
- ROM song0 = {8'hF1, 8'h00}; start → key_code 2B for 60 cycles, F0 for 4, then done pulse, playing 0.
- song_sel=1, song1 = {8'hF5, 8'hFF, 8'h00} → rom_addr 8,9,10; key_code 42, then F0 for full rest.
- pause 20 cycles mid-note → key_code F0 during pause; total note time extended by exactly 20 cycles.
- stop mid-note → key_code F0 and playing 0 next cycle, no done; start again restarts from step 0.
- Eight notes, no marker → ends after step 7; with SONG_SEQ_LOOP_EN and loop=1 → rom_addr wraps to 0, no done.
- k_tr low mid-play → outputs at reset values immediately; duration code 0 note → skipped, key_code F0.
